hs4_sync_rx: RTL and testbench

- Parametrised four-phase bundled-data receiver. It is the clocked successor to the latch bank: it replaces open latch enables with a full req/ack handshake and a DEPTH-entry buffer.
- Takes an asynchronous req_in/data_in channel from self-timed logic, synchronises req_in into clk, and captures data into a circular buffer.
- Presents captured words as a valid/ready stream to synchronous logic.
- Sits at every async-to-sync boundary in the design.

---
 rtl/hs_pkg.sv | 15 +
 rtl/sync_chain.sv | 24 ++
 rtl/hs4_sync_rx.sv | 109 ++++++++++
 tb/tb_hs4_sync_rx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared definitions for the four-phase handshake blocks: FSM state encoding
// and the occupancy-counter width helper.
package hs_pkg;

  typedef enum logic {
    HS_IDLE     = 1'b0,
    HS_WAIT_LOW = 1'b1
  } hs_state_t;

  // Occupancy runs 0..depth inclusive, hence one bit more than the pointer.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain for bringing a single asynchronous bit into the clk domain.
module sync_chain #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ff <= {STAGES{RESET_BIT}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/hs4_sync_rx.sv
// Four-phase bundled-data receiver: synchronises req_in, acknowledges, and
// buffers captured words into a DEPTH-entry circular buffer read as valid/ready.
module hs4_sync_rx
  import hs_pkg::*;
#(
  parameter int unsigned          DATA_BITS   = 8,
  parameter int unsigned          DEPTH       = 4,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [DATA_BITS-1:0] RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          req_in,
  input  logic [DATA_BITS-1:0]          data_in,
  output logic                          ack_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_BITS-1:0]          out_data,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int unsigned    PW         = $clog2(DEPTH);
  localparam int unsigned    LW         = level_width(DEPTH);
  localparam logic [LW-1:0]  FULL_LEVEL = LW'(DEPTH);

  hs_state_t             state_q, state_d;
  logic                  ack_d;
  logic                  req_s;
  logic                  push, pop, full;
  logic [PW-1:0]         wptr, rptr;
  logic [DATA_BITS-1:0]  mem [DEPTH];

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_BIT (1'b0)
  ) u_req_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (req_in),
    .q    (req_s)
  );

  assign full      = (level == FULL_LEVEL);
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= HS_IDLE;
      ack_out <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_out <= ack_d;
    end
  end

  // full is taken from the registered level, so a pop in the same cycle
  // frees space for the stalled request only on the following edge.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_out;
    push    = 1'b0;
    unique case (state_q)
      HS_IDLE: begin
        if (req_s && !full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = HS_WAIT_LOW;
        end
      end
      HS_WAIT_LOW: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = HS_IDLE;
        end
      end
      default: begin
        state_d = HS_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VALUE;
      end
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= data_in;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_hs4_sync_rx.sv
// Directed bench for hs4_sync_rx: cycle vector table plus handshake sequences
// on the default build and two parameter variants.
module tb_hs4_sync_rx;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // default build
  logic       req_in, ack_out, out_valid, out_ready;
  logic [7:0] data_in, out_data;
  logic [2:0] level;
  // DEPTH=2, SYNC_STAGES=3
  logic       req2, ack2, vld2, rdy2;
  logic [7:0] dat2, od2;
  logic [1:0] lvl2;
  // DEPTH=8, DATA_BITS=16
  logic        req8, ack8, vld8, rdy8;
  logic [15:0] dat8, od8;
  logic [3:0]  lvl8;

  hs4_sync_rx dut (
    .clk(clk), .rstn(rstn), .req_in(req_in), .data_in(data_in), .ack_out(ack_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level)
  );

  hs4_sync_rx #(.DEPTH(2), .SYNC_STAGES(3)) dut_d2 (
    .clk(clk), .rstn(rstn), .req_in(req2), .data_in(dat2), .ack_out(ack2),
    .out_valid(vld2), .out_ready(rdy2), .out_data(od2), .level(lvl2)
  );

  hs4_sync_rx #(.DEPTH(8), .DATA_BITS(16)) dut_d8 (
    .clk(clk), .rstn(rstn), .req_in(req8), .data_in(dat8), .ack_out(ack8),
    .out_valid(vld8), .out_ready(rdy8), .out_data(od8), .level(lvl8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       req;
    logic [7:0] d;
    logic       rdy;
    logic       ack;
    logic       vld;
    logic [7:0] q;
    logic [2:0] lvl;
  } vec_t;
  vec_t tbl [9];

  // pop recorder for the wrap-around phase
  logic       wrap_watch = 1'b0;
  logic [7:0] popped [$];
  int         max_lvl = 0;

  always @(negedge clk) begin
    if (wrap_watch) begin
      if (out_valid && out_ready) popped.push_back(out_data);
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int w);
    case (w)
      0:       return ack_out;
      1:       return ack2;
      default: return ack8;
    endcase
  endfunction

  task automatic drive(input int w, input logic r, input logic [15:0] d);
    case (w)
      0:       begin req_in = r; data_in = d[7:0]; end
      1:       begin req2   = r; dat2    = d[7:0]; end
      default: begin req8   = r; dat8    = d;      end
    endcase
  endtask

  // Edges from now until ack reaches v; -1 if it never does within 20 edges.
  task automatic wait_ack(input int w, input logic v, output int n);
    n = 0;
    while (ack_of(w) !== v && n < 20) begin
      step();
      n++;
    end
    if (ack_of(w) !== v) n = -1;
  endtask

  task automatic xfer(input int w, input logic [15:0] d, input int lat);
    int n;
    drive(w, 1'b1, d);
    wait_ack(w, 1'b1, n);
    chk($sformatf("ack_rise_lat_dut%0d_%0h", w, d), n, lat);
    drive(w, 1'b0, d);
    wait_ack(w, 1'b0, n);
    chk($sformatf("ack_fall_lat_dut%0d_%0h", w, d), n, lat);
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[2] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1};
    tbl[3] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1};
    tbl[4] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1};
    tbl[5] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};

    rstn = 1'b0;
    req_in = 1'b0; data_in = '0; out_ready = 1'b0;
    req2 = 1'b0; dat2 = '0; rdy2 = 1'b0;
    req8 = 1'b0; dat8 = '0; rdy8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level_d2", lvl2, 0);
    chk("rst_data_d8", od8, 0);
    rstn = 1'b1;

    // single transfer, then pop and an ignored ready while empty
    for (int i = 0; i < 9; i++) begin
      req_in = tbl[i].req; data_in = tbl[i].d; out_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_ack", i), ack_out, tbl[i].ack);
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].vld);
      chk($sformatf("vec%0d_data", i), out_data, tbl[i].q);
      chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
    end

    // fill and backpressure
    for (int i = 1; i <= 4; i++) xfer(0, 16'(i), 3);
    chk("fill_level", level, 4);
    chk("fill_head", out_data, 8'h01);
    drive(0, 1'b1, 16'h05);
    repeat (8) step();
    chk("bp_ack_held_low", ack_out, 0);
    chk("bp_level", level, 4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_pop_level", level, 3);
    chk("bp_pop_head", out_data, 8'h02);
    chk("bp_no_same_cycle_push", ack_out, 0);
    step();
    chk("bp_late_push_ack", ack_out, 1);
    chk("bp_late_push_level", level, 4);
    drive(0, 1'b0, 16'h05);
    wait_ack(0, 1'b0, n);
    chk("bp_ack_fall_lat", n, 3);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("bp_drain_%0d", i), out_data, 8'(i));
      step();
    end
    out_ready = 1'b0;
    chk("bp_drained_level", level, 0);

    // simultaneous push and pop
    xfer(0, 16'h01, 3);
    xfer(0, 16'h02, 3);
    chk("pp_level_before", level, 2);
    drive(0, 1'b1, 16'h03);
    step();
    step();
    chk("pp_ack_not_yet", ack_out, 0);
    chk("pp_head_01", out_data, 8'h01);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp_ack", ack_out, 1);
    chk("pp_level_same", level, 2);
    chk("pp_head_02", out_data, 8'h02);
    drive(0, 1'b0, 16'h03);
    wait_ack(0, 1'b0, n);
    chk("pp_ack_fall_lat", n, 3);
    out_ready = 1'b1;
    chk("pp_out_02", out_data, 8'h02);
    step();
    chk("pp_out_03", out_data, 8'h03);
    step();
    out_ready = 1'b0;
    chk("pp_final_level", level, 0);

    // streaming across several pointer wraps
    out_ready = 1'b1;
    wrap_watch = 1'b1;
    for (int i = 0; i < 10; i++) xfer(0, 16'h30 + 16'(i * 7), 3);
    step();
    step();
    wrap_watch = 1'b0;
    out_ready = 1'b0;
    chk("wrap_count", popped.size(), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      chk($sformatf("wrap_word%0d", i), popped[i], 8'(8'h30 + i * 7));
    chk("wrap_max_level", max_lvl, 1);

    // parameter variants: latency and full threshold
    xfer(1, 16'h11, 4);
    xfer(1, 16'h22, 4);
    chk("d2_level_full", lvl2, 2);
    drive(1, 1'b1, 16'h33);
    repeat (10) step();
    chk("d2_stall_ack", ack2, 0);
    chk("d2_stall_level", lvl2, 2);
    chk("d2_head", od2, 8'h11);
    drive(1, 1'b0, 16'h33);
    repeat (5) step();
    for (int i = 0; i < 8; i++) xfer(2, 16'hA000 + 16'(i), 3);
    chk("d8_level_full", lvl8, 8);
    drive(2, 1'b1, 16'hBEEF);
    repeat (10) step();
    chk("d8_stall_ack", ack8, 0);
    chk("d8_stall_level", lvl8, 8);
    chk("d8_head", od8, 16'hA000);
    drive(2, 1'b0, 16'h0);
    repeat (5) step();

    // reset while waiting for req_in low with three words buffered
    xfer(0, 16'h41, 3);
    xfer(0, 16'h42, 3);
    drive(0, 1'b1, 16'h43);
    wait_ack(0, 1'b1, n);
    chk("mid_ack_rise_lat", n, 3);
    chk("mid_level3", level, 3);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_ack", ack_out, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_level_d8", lvl8, 0);
    drive(0, 1'b0, 16'h0);
    step();
    step();
    rstn = 1'b1;
    repeat (6) step();
    chk("post_rst_ack", ack_out, 0);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_level", level, 0);
    chk("post_rst_data", out_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
